// File: rtl/vga_text_vram_arb.sv
// rtl/vga_text_vram_arb.sv - single-port character VRAM arbiter: display fetch vs CPU req/ack port
// Optional clear-screen engine is built when VGA_VRAM_CLEAR_EN is defined.
module vga_text_vram_arb #(
    parameter int COLS       = 70,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 12,
    parameter int FETCH_SLOT = 0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              valid,
    input  logic [6:0]        h_char,
    input  logic [4:0]        v_char,
    input  logic [3:0]        h_font,
    output logic [7:0]        char_code,
    output logic              char_vld,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              clr_start,
    output logic              clr_busy
);
    localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);

    typedef enum logic [2:0] {
        IDLE,
        DISP_RD,
        DISP_CAP,
        CPU_RD,
        CPU_WR,
        CPU_ACK
`ifdef VGA_VRAM_CLEAR_EN
        , CLR_WR
`endif
    } state_t;

    state_t            state, state_nx;
    logic              trig, disp_work;
    logic              live_oob, cpu_oob;
    logic [ADDR_W-1:0] live_addr;
    logic              disp_pend, pend_oob;
    logic [ADDR_W-1:0] pend_addr;
    logic              cur_oob;
    logic              rd_fwd;
    logic              disp_go, cpu_go;
    logic              cpu_block;

    assign trig      = valid && (h_font == 4'(FETCH_SLOT));
    assign disp_work = trig || disp_pend;
    assign live_oob  = (32'(h_char) >= 32'(COLS)) || (32'(v_char) >= 32'(ROWS));
    assign live_addr = ADDR_W'(32'(v_char) * 32'(COLS) + 32'(h_char));
    assign cpu_oob   = (cpu_addr >= CELLS);

    // Read data is the RAM's own output register, gated onto the bus in the ack cycle.
    assign cpu_rdata = (cpu_ack && rd_fwd) ? ram_rdata : 8'h00;

`ifdef VGA_VRAM_CLEAR_EN
    logic              clr_go;
    logic [ADDR_W-1:0] clr_ptr;

    assign cpu_block = clr_busy || clr_start;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            clr_busy <= 1'b0;
            clr_ptr  <= '0;
        end else if (clr_start) begin
            clr_busy <= 1'b1;
            clr_ptr  <= '0;
        end else begin
            if (clr_go)
                clr_ptr <= clr_ptr + 1'b1;
            if (state == CLR_WR && ram_addr == CELLS - 1'b1)
                clr_busy <= 1'b0;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = clr_start;
    assign cpu_block  = 1'b0;
    assign clr_busy   = 1'b0;
`endif

    // CPU_ACK can hand straight over to a waiting display fetch so a deferred cell still meets its slot.
    always_comb begin
        state_nx = state;
        disp_go  = 1'b0;
        cpu_go   = 1'b0;
`ifdef VGA_VRAM_CLEAR_EN
        clr_go   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (disp_work) begin
                    disp_go  = 1'b1;
                    state_nx = DISP_RD;
`ifdef VGA_VRAM_CLEAR_EN
                end else if (clr_busy && !clr_start) begin
                    clr_go   = 1'b1;
                    state_nx = CLR_WR;
`endif
                end else if (cpu_req && !cpu_block) begin
                    cpu_go   = 1'b1;
                    state_nx = cpu_we ? CPU_WR : CPU_RD;
                end
            end
            DISP_RD:        state_nx = DISP_CAP;
            DISP_CAP:       state_nx = IDLE;
            CPU_RD, CPU_WR: state_nx = CPU_ACK;
            CPU_ACK: begin
                if (disp_work) begin
                    disp_go  = 1'b1;
                    state_nx = DISP_RD;
                end else begin
                    state_nx = IDLE;
                end
            end
`ifdef VGA_VRAM_CLEAR_EN
            CLR_WR:         state_nx = IDLE;
`endif
            default:        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            disp_pend <= 1'b0;
            pend_oob  <= 1'b0;
            pend_addr <= '0;
            cur_oob   <= 1'b0;
            rd_fwd    <= 1'b0;
            char_code <= 8'h00;
            char_vld  <= 1'b0;
            cpu_ack   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'h00;
        end else begin
            state    <= state_nx;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            char_vld <= 1'b0;
            cpu_ack  <= 1'b0;

            // A live trigger always wins over (and retires) a pending one.
            if (disp_go) begin
                disp_pend <= 1'b0;
                cur_oob   <= trig ? live_oob : pend_oob;
                ram_addr  <= trig ? live_addr : pend_addr;
                ram_en    <= !(trig ? live_oob : pend_oob);
            end else if (trig) begin
                disp_pend <= 1'b1;
                pend_addr <= live_addr;
                pend_oob  <= live_oob;
            end

            if (cpu_go) begin
                ram_en    <= !cpu_oob;
                ram_we    <= cpu_we && !cpu_oob;
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
                rd_fwd    <= !cpu_we && !cpu_oob;
            end

`ifdef VGA_VRAM_CLEAR_EN
            if (clr_go) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= clr_ptr;
                ram_wdata <= 8'h00;
            end
`endif

            if (state == DISP_CAP) begin
                char_code <= cur_oob ? 8'h00 : ram_rdata;
                char_vld  <= 1'b1;
            end

            if (state == CPU_RD || state == CPU_WR)
                cpu_ack <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_text_vram_arb.sv
// tb/tb_vga_text_vram_arb.sv - randomized self-checking bench for vga_text_vram_arb
module tb_vga_text_vram_arb;
    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        valid, cpu_req, cpu_we, clr_start, fill_en;
    logic [6:0]  h_char;
    logic [4:0]  v_char;
    logic [3:0]  h_font;
    logic [11:0] cpu_addr, ram_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, char_code, ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        char_vld, cpu_ack, ram_en, ram_we, clr_busy;

    always #5 pclk = ~pclk;

    vga_text_vram_arb #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .FETCH_SLOT(0)) dut (
        .pclk(pclk), .rst(rst), .valid(valid), .h_char(h_char), .v_char(v_char),
        .h_font(h_font), .char_code(char_code), .char_vld(char_vld),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy)
    );

    logic [7:0] mem  [4096];
    logic [7:0] gold [4096];

    always @(posedge pclk) begin
        if (fill_en) begin
            for (int i = 0; i < 4096; i++) mem[i] <= gold[i];
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic fill();
        fill_en = 1'b1;
        tick();
        fill_en = 1'b0;
    endtask

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic        oob;
        logic [11:0] a;
    } trig_t;
    trig_t dq[$];
    logic  prev_en = 1'b0;

    always @(negedge pclk) begin
        trig_t e;
        if (rst) begin
            dq.delete();
        end else begin
            if (valid && h_font == 4'd0) begin
                e.t   = cyc;
                e.oob = (int'(h_char) >= COLS) || (int'(v_char) >= ROWS);
                e.a   = 12'(int'(v_char) * COLS + int'(h_char));
                dq.push_back(e);
            end
            if (char_vld) begin
                if (dq.size() == 0) begin
                    check("disp_spurious_vld", 64'(1), 64'(0));
                end else begin
                    e = dq.pop_front();
                    check("disp_latency_3to5", 64'((cyc - e.t) >= 3 && (cyc - e.t) <= 5), 64'(1));
                    check("disp_char_code", 64'(char_code), 64'(e.oob ? 8'h00 : gold[e.a]));
                end
            end else if (dq.size() > 0 && (cyc - dq[0].t) > 5) begin
                check("disp_timeout", 64'(0), 64'(1));
                void'(dq.pop_front());
            end
            if (ram_en) check("ram_en_one_cycle", 64'(prev_en), 64'(0));
            if (ram_en && ram_we && !clr_busy)
                check("ram_write_source", 64'({cpu_req, cpu_we, cpu_addr, cpu_wdata}),
                      64'({1'b1, 1'b1, ram_addr, ram_wdata}));
        end
        prev_en <= ram_en;
    end

    task automatic cpu_xact(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd);
        logic [7:0] exp_rd;
        int         nwe;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        lat       = 0;
        nwe       = 0;
        exp_rd    = (int'(addr) < CELLS) ? gold[addr] : 8'h00;
        do begin
            @(negedge pclk);
            lat++;
            if (ram_we) nwe++;
        end while (!cpu_ack && lat < 40);
        check("cpu_ack_seen", 64'(cpu_ack), 64'(1));
        rd = cpu_rdata;
        if (!we) check("cpu_rdata", 64'(cpu_rdata), 64'(exp_rd));
        else if (int'(addr) < CELLS) gold[addr] = wd;
        check("cpu_ram_we_cycles", 64'(nwe), 64'((we && int'(addr) < CELLS) ? 1 : 0));
        tick();
        cpu_req = 1'b0;
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({char_code, char_vld, cpu_ack, cpu_rdata, ram_en, ram_we,
                    ram_addr, ram_wdata, clr_busy});
    endfunction

    int         lat;
    logic [7:0] rdv;
    logic       disp_done;
    int         oh[3] = '{75, 0, 69};
    int         ov[3] = '{0, 30, 29};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        valid = 0; h_char = 0; v_char = 0; h_font = 4'd1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        clr_start = 0; fill_en = 0; disp_done = 0;
        for (int i = 0; i < 4096; i++) gold[i] = 8'($urandom);
        gold[145]  = 8'h41;
        gold[73]   = 8'h37;
        gold[4000] = 8'hA5;
        gold[2100] = 8'h96;
        tick();
        fill();
        @(negedge pclk);
        check("reset_outputs", outs_vec(), 64'(0));
        tick();
        rst = 0;
        tick();

        valid = 1; v_char = 2; h_char = 5; h_font = 4'd0;
        tick();
        valid = 0; h_font = 4'd1;
        #2 rst = 1;
        @(negedge pclk);
        check("reset_mid_disp_rd", outs_vec(), 64'(0));
        tick();
        rst = 0;
        tick();

        valid = 1; v_char = 2; h_char = 5; h_font = 4'd0;
        tick();
        valid = 0; h_font = 4'd1;
        @(negedge pclk);
        check("fetch_t1_ram", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 12'd145}));
        tick();
        @(negedge pclk);
        check("fetch_t2_idle", 64'({ram_en, char_vld}), 64'(0));
        tick();
        @(negedge pclk);
        check("fetch_t3_char", 64'({char_vld, char_code}), 64'({1'b1, 8'h41}));
        tick();
        @(negedge pclk);
        check("fetch_t4_vld_low", 64'(char_vld), 64'(0));
        tick();

        cpu_xact(1'b1, 12'd300, 8'h5A, lat, rdv);
        check("cpu_wr_latency", 64'(lat), 64'(3));
        cpu_xact(1'b0, 12'd300, 8'h00, lat, rdv);
        check("cpu_rd_latency", 64'(lat), 64'(3));
        check("cpu_rd_300", 64'(rdv), 64'(8'h5A));

        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'd145;
        tick();
        valid = 1; v_char = 1; h_char = 3; h_font = 4'd0;
        @(negedge pclk);
        check("mix_t1_cpu_ram", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 12'd145}));
        tick();
        valid = 0; h_font = 4'd1;
        @(negedge pclk);
        check("mix_t2_ack", 64'({cpu_ack, cpu_rdata, ram_en}), 64'({1'b1, 8'h41, 1'b0}));
        tick();
        cpu_req = 0;
        @(negedge pclk);
        check("mix_t3_disp_ram", 64'({ram_en, ram_addr}), 64'({1'b1, 12'd73}));
        tick();
        @(negedge pclk);
        check("mix_t4_vld_low", 64'(char_vld), 64'(0));
        tick();
        @(negedge pclk);
        check("mix_t5_char", 64'({char_vld, char_code}), 64'({1'b1, 8'h37}));
        tick();

        cpu_xact(1'b1, 12'd2100, 8'hC3, lat, rdv);
        check("oob_wr_latency", 64'(lat), 64'(3));
        cpu_xact(1'b0, 12'd4000, 8'h00, lat, rdv);
        check("oob_rd_zero", 64'(rdv), 64'(0));
        cpu_xact(1'b0, 12'd2100, 8'h00, lat, rdv);
        check("oob_rd_2100_zero", 64'(rdv), 64'(0));
        cpu_xact(1'b0, 12'd2099, 8'h00, lat, rdv);

        for (int k = 0; k < 3; k++) begin
            valid = 1; h_char = 7'(oh[k]); v_char = 5'(ov[k]); h_font = 4'd0;
            tick();
            valid = 0; h_font = 4'd1;
            @(negedge pclk);
            check("cell_ram_en", 64'(ram_en), 64'(k == 2));
            tick();
            tick();
            @(negedge pclk);
            check("cell_char", 64'({char_vld, char_code}), 64'({1'b1, (k == 2) ? gold[2099] : 8'h00}));
            tick();
        end

        fork
            begin
                for (int c = 0; c < 300; c++) begin
                    logic       vv;
                    logic [6:0] hh;
                    logic [4:0] vr;
                    vv = ($urandom_range(0, 3) != 0);
                    hh = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(70, 127)) : 7'($urandom_range(0, 69));
                    vr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(30, 31)) : 5'($urandom_range(0, 29));
                    for (int f = 0; f < 9; f++) begin
                        valid = vv; h_char = hh; v_char = vr; h_font = 4'(f);
                        tick();
                    end
                end
                valid = 0; h_font = 4'd1;
                disp_done = 1;
            end
            begin
                while (!disp_done) begin
                    logic [11:0] a;
                    int          l;
                    logic [7:0]  r;
                    repeat ($urandom_range(1, 6)) tick();
                    a = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2100, 4095)) : 12'($urandom_range(0, 2099));
                    cpu_xact(1'($urandom), a, 8'($urandom), l, r);
                end
            end
        join
        tick();
        tick();

`ifdef VGA_VRAM_CLEAR_EN
        begin
            int   nw, nbad, nack_busy;
            logic acked;
            clr_start = 1;
            tick();
            clr_start = 0;
            @(negedge pclk);
            check("clr_busy_set", 64'(clr_busy), 64'(1));
            tick();
            cpu_req = 1; cpu_we = 1; cpu_addr = 12'd10; cpu_wdata = 8'h77;
            nw = 0; nbad = 0; nack_busy = 0; acked = 0;
            for (int n = 0; n < 6000 && !acked; n++) begin
                @(negedge pclk);
                if (ram_en && ram_we && clr_busy) begin
                    if (ram_addr != 12'(nw) || ram_wdata != 8'h00) nbad++;
                    nw++;
                end
                if (cpu_ack) begin
                    acked = 1;
                    if (clr_busy) nack_busy++;
                end
            end
            check("clr_write_count", 64'(nw), 64'(CELLS));
            check("clr_bad_writes", 64'(nbad), 64'(0));
            check("clr_cpu_acked", 64'(acked), 64'(1));
            check("clr_ack_while_busy", 64'(nack_busy), 64'(0));
            check("clr_busy_done", 64'(clr_busy), 64'(0));
            tick();
            cpu_req = 0;
            for (int i = 0; i < CELLS; i++) gold[i] = 8'h00;
            gold[10] = 8'h77;
            cpu_xact(1'b0, 12'd10, 8'h00, lat, rdv);
            cpu_xact(1'b0, 12'd2099, 8'h00, lat, rdv);
            check("clr_last_cell_zero", 64'(rdv), 64'(0));
        end
`else
        clr_start = 1;
        tick();
        clr_start = 0;
        @(negedge pclk);
        check("clr_busy_tied_low", 64'(clr_busy), 64'(0));
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
